sp_interp_sequencer: RTL
========================

Name: sp_interp_sequencer

Overview:
Sequencer that feeds the combinational sub-pixel interpolator (sp_interpolator) from a byte-serial pixel stream and returns its 15 results as a serial stream. It assembles an 8x8 window, holds it stable for a settle time, captures the 15 outputs into a result buffer, and drains them with valid/ready. Loading of the next window overlaps draining of the previous results. Sits between the frame-fetch stream and the result writer; sp_interpolator is instantiated beside it, not inside it.

Parameters:
SETTLE_CYCLES, 2, cycles the window is held stable before capture; legal range is >= 1.
CNT_W, 16, width of the completed-window counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
pix_in  in  8  incoming pixel.
pix_valid  in  1  pix_in is valid.
pix_ready  out  1  sequencer accepts a pixel.
win_flat  out  512  window to the interpolator; byte k at bits [8k+7:8k]; k=0 drives I11, k=7 drives I18, k=8 drives I21, k=63 drives I88.
win_valid  out  1  window complete and held stable.
interp_res  in  120  interpolator outputs; byte order 0..14 is a44,b44,c44,d,h,n,e,i,p,f,j,q,g,k,r.
res_data  out  8  current result byte.
res_idx  out  4  index of res_data, 0..14.
res_valid  out  1  res_data is valid.
res_ready  in  1  downstream accepts.
res_last  out  1  res_valid and res_idx==14.
win_count  out  CNT_W  number of captured windows.

Behaviour:
- A transfer occurs on a clock edge where valid&ready are both high, on either interface.
- Load FSM states:
  - LOAD: pix_ready=1, win_valid=0. Each accepted pixel is written to byte ptr, then ptr increments. Gaps in pix_valid are allowed. The accept at ptr=63 moves the FSM to SETTLE and resets ptr to 0.
  - SETTLE: pix_ready=0, win_valid=1, window registers frozen. The settle counter counts SETTLE_CYCLES cycles, then the FSM moves to HOLD.
  - HOLD: pix_ready=0, win_valid=1. Capture happens on the first edge where the result buffer is free. On capture the FSM returns to LOAD.
- Result buffer is free when it is empty, or when its res_last transfer occurs on that same edge. In the same-edge case, capture and final drain coincide: res_valid stays 1 and res_idx goes 14->0 with no bubble.
- Capture: interp_res is registered into the 15-byte buffer, res_idx=0, res_valid=1 from the next cycle, and win_count increments. win_count wraps from all-ones to 0.
- HOLD may last zero cycles. If the buffer is free at the end of SETTLE, capture happens on the edge of the last SETTLE cycle.
- Latency with the buffer free:
  - 64th pixel accepted at edge E.
  - win_valid=1 for cycles E+1 .. E+SETTLE_CYCLES.
  - Capture at edge E+SETTLE_CYCLES.
  - res_valid and pix_ready are 1 from the next cycle.
- Drain:
  - res_data = buffer[res_idx].
  - res_data and res_idx hold stable while res_valid & ~res_ready.
  - On each transfer res_idx increments. The transfer at idx 14 clears res_valid unless a capture coincides with it.
- Window registers change only on LOAD accepts. Loading the next window does not disturb the result buffer.
- pix_valid while pix_ready=0 is ignored; no write occurs.
- Reset: while rst is sampled high, the next edge does the following:
  - State goes to LOAD; ptr, settle counter, res_idx and win_count go to 0.
  - The result buffer is emptied; window registers are cleared to 0.
  - Outputs after that edge: res_valid=0, win_valid=0, res_last=0, res_data=0, win_flat=0, win_count=0.
  - pix_ready is forced to 0 combinationally while rst=1, and is 1 in the first cycle after rst deasserts.
  - Reset mid-load or mid-drain discards partial windows and undrained results; no transfer occurs on that edge.

Test Plan:
1. All 64 pixels =10, res_ready=1, SETTLE_CYCLES=2, real sp_interpolator attached -> 15 bytes of 10 with res_idx 0..14, res_last only at idx 14; win_count=1; res_valid rises 3 cycles after the 64th accept.
2. Pixels 0..63 in order -> win_flat byte k == k; pix_ready=0 during SETTLE/HOLD. Then pixels with I14..I84 column = 1..8 and others 10 -> results a44=4, b44=4, c44=5, d=e=f=5, g=6, h=i=j=k=6, n=p=q=r=9.
3. Backpressure: res_ready pattern 1,0,0,1,... -> res_data/res_idx stable during stalls, all 15 bytes delivered exactly once, in order.
4. Overlap: second window fully loaded while res_ready=0 -> FSM in HOLD with win_valid=1; raise res_ready -> capture on the idx-14 transfer edge, res_valid continuous, res_idx 14->0, win_count=2.
5. Random pix_valid gaps (~50% duty) -> window contents identical to the gap-free case; no extra or missing writes.
6. rst pulsed for 1 cycle after 30 pixels, and again mid-drain at idx 7 -> all outputs 0 on the next cycle, pix_ready=1 after; the next 64 pixels form a fresh window with win_count=1.

Source files
------------

// File: rtl/sp_interp_sequencer.sv
`timescale 1ns/1ps
// sp_interp_sequencer: assembles an 8x8 byte window for the sub-pixel
// interpolator, holds it while the interpolator settles, captures its 15
// result bytes and drains them as a valid/ready byte stream. Loading the
// next window overlaps draining of the previous results.
module sp_interp_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [511:0]     win_flat,
  output logic             win_valid,
  input  logic [119:0]     interp_res,
  output logic [7:0]       res_data,
  output logic [3:0]       res_idx,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_last,
  output logic [CNT_W-1:0] win_count
);

  localparam int unsigned PTR_W = 6;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned WIN_W = 512;
  localparam int unsigned RES_W = 120;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(63);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(14);
  localparam logic [SET_W-1:0] SETTLE_END = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [SET_W-1:0]   settle_cnt, settle_nxt;
  logic [WIN_W-1:0]   win;
  logic [RES_W-1:0]   res_buf;
  logic               pix_acc_c;
  logic               res_xfer_c;
  logic               buf_free_c;
  logic               capture_c;

  // Buffer can take a new capture when empty or when its last byte leaves now
  assign res_xfer_c = res_valid & res_ready;
  assign buf_free_c = ~res_valid | (res_xfer_c & (res_idx == LAST_IDX));
  assign pix_acc_c  = pix_valid & pix_ready;

  // Load FSM state register and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_LOAD;
      ptr        <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  // Load FSM next-state, handshake and capture decode
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    settle_nxt = settle_cnt;
    capture_c  = 1'b0;
    pix_ready  = 1'b0;
    win_valid  = 1'b0;
    case (state)
      ST_LOAD: begin
        pix_ready = ~rst;
        if (pix_valid & ~rst) begin
          ptr_nxt = ptr + PTR_W'(1);
          if (ptr == LAST_PTR) begin
            state_nxt = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        win_valid = 1'b1;
        if (settle_cnt == SETTLE_END) begin
          settle_nxt = '0;
          if (buf_free_c) begin
            capture_c = 1'b1;
            state_nxt = ST_LOAD;
          end else begin
            state_nxt = ST_HOLD;
          end
        end else begin
          settle_nxt = settle_cnt + SET_W'(1);
        end
      end
      ST_HOLD: begin
        win_valid = 1'b1;
        if (buf_free_c) begin
          capture_c = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // Window registers: written only by accepted pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      win <= '0;
    end else if (pix_acc_c) begin
      win[{ptr, 3'b000} +: 8] <= pix_in;
    end
  end

  // Result buffer: capture takes priority and may coincide with the final drain
  always_ff @(posedge clk) begin
    if (rst) begin
      res_buf   <= '0;
      res_idx   <= '0;
      res_valid <= 1'b0;
      win_count <= '0;
    end else if (capture_c) begin
      res_buf   <= interp_res;
      res_idx   <= '0;
      res_valid <= 1'b1;
      win_count <= win_count + CNT_W'(1);
    end else if (res_xfer_c) begin
      if (res_idx == LAST_IDX) begin
        res_idx   <= '0;
        res_valid <= 1'b0;
      end else begin
        res_idx <= res_idx + IDX_W'(1);
      end
    end
  end

  assign win_flat = win;
  assign res_data = 8'(res_buf >> {res_idx, 3'b000});
  assign res_last = res_valid & (res_idx == LAST_IDX);

endmodule
